// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the buffered transmitter.
package uart_pkg;

    // Default bit period in clock cycles, common to RX and TX.
    localparam int BAUD_DIV_DEFAULT = 868;

    // Serializer phases of one 8N1 frame.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// DEPTH x 8 synchronous FIFO with a fall-through head: rd_data is valid
// whenever the FIFO is not empty, so a pop consumes the byte already shown.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 wr_data,
    input  logic                       pop,
    output logic [7:0]                 rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses a push even when a pop happens in the same cycle,
    // and an empty FIFO ignores a pop even when a push happens alongside it.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full    = (count == NW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage write; contents are only meaningful between the pointers.
    // NOTE: the data array is deliberately left out of reset -- emptiness is
    // tracked by count, and resetting the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes are queued in a byte_fifo and sent
// back to back, with no idle gap while the queue holds data.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int DEPTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       uart_tx,
    output logic                       tx_busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);
    localparam int            CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    tx_state_t     state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_end;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [7:0]    head;

    assign in_ready = !fifo_full;
    assign bit_end  = (bit_cnt == CNT_LAST);

    // A byte leaves the queue when idle, or at the very end of a stop bit so
    // the next start bit follows without a gap.
    assign fifo_pop = !fifo_empty &&
                      ((state == TX_IDLE) || (state == TX_STOP && bit_end));

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Sticky record of any byte refused because the queue was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (in_valid && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Frame serializer: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        shift   <= head;
                        uart_tx <= 1'b0;
                        bit_cnt <= '0;
                        tx_busy <= 1'b1;
                        state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        uart_tx <= shift[0];
                        shift   <= shift >> 1;
                        state   <= TX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (!fifo_empty) begin
                            shift   <= head;
                            uart_tx <= 1'b0;
                            state   <= TX_START;
                        end else begin
                            tx_busy <= 1'b0;
                            state   <= TX_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= TX_IDLE;
                end
            endcase
        end
    end

endmodule
